// File: rtl/mor1kx_pipeline_sequencer_cappuccino.sv
// Cappuccino pipeline-advance sequencer: per-stage advance strobes in normal flow, and an
// exception/l.rfe sequence of LSU drain, timed flush and a one-cycle fetch redirect.

`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

module mor1kx_pipeline_sequencer_cappuccino #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
        {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0},
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_valid_i,
    input  logic                            decode_valid_i,
    input  logic                            execute_valid_i,
    input  logic                            ctrl_valid_i,
    input  logic                            ctrl_except_i,
    input  logic                            ctrl_op_rfe_i,
    input  logic                            lsu_busy_i,
    input  logic                            du_stall_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] except_vector_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] epcr_i,
    output logic                            padv_fetch_o,
    output logic                            padv_decode_o,
    output logic                            padv_execute_o,
    output logic                            padv_ctrl_o,
    output logic                            execute_bubble_o,
    output logic                            pipeline_flush_o,
    output logic                            redirect_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic [1:0]                      seq_state_o
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDrain    = 2'd1,
        StFlush    = 2'd2,
        StRedirect = 2'd3
    } state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic                            flush_q, flush_d;
    logic                            redirect_q, redirect_d;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_q, pc_d;

    logic event_w;
    logic padv_ctrl_w;

    assign event_w = ctrl_valid_i & (ctrl_except_i | ctrl_op_rfe_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        padv_ctrl_w = 1'b0;
        unique case (state_q)
            StRun: begin
                padv_ctrl_w = ctrl_valid_i & ~du_stall_i & ~event_w;
                // Debug stall only gates advance; a ctrl-stage event is still taken.
                if (event_w) begin
                    pc_d = ctrl_except_i ? except_vector_i : epcr_i;
                    if (lsu_busy_i) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = FlushLoad;
                    end
                end
            end
            StDrain: begin
                if (!lsu_busy_i) begin
                    state_d = StFlush;
                    cnt_d   = FlushLoad;
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedirect: begin
                state_d = StRun;
            end
        endcase
        // Strobes are registered so they line up exactly with the state they describe.
        flush_d    = (state_d == StFlush);
        redirect_d = (state_d == StRedirect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            cnt_q      <= 4'd0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            pc_q       <= OPTION_RESET_PC;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        padv_ctrl_o      = padv_ctrl_w & ~rst;
        padv_execute_o   = padv_ctrl_o & execute_valid_i;
        padv_decode_o    = padv_execute_o & decode_valid_i;
        padv_fetch_o     = padv_decode_o & fetch_valid_i;
        execute_bubble_o = padv_ctrl_o & ~execute_valid_i;
    end

    assign pipeline_flush_o = flush_q;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = pc_q;
    assign seq_state_o      = state_q;

    flush_cycles_legal_a: assert property (@(posedge clk) FLUSH_CYCLES inside {[1:15]});

endmodule
